// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared constants and target helpers for the fetch-stage PC controller.
// Covers the reset PC, the exception vectors and the jump/branch target arithmetic.
package pc_fetch_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] PKG_RESET_PC    = 32'hBFC0_0000;
  localparam logic [XLEN-1:0] EXC_VEC_BOOT    = 32'hBFC0_0380;
  localparam logic [XLEN-1:0] EXC_VEC_NORMAL  = 32'h8000_0180;

  // j/jal keep the region bits of the delay-slot address, not of the jump itself.
  function automatic logic [XLEN-1:0] j_target(input logic [XLEN-1:0] pc,
                                               input logic [25:0] idx);
    logic [XLEN-1:0] pc_plus4;
    pc_plus4 = pc + 32'd4;
    return {pc_plus4[31:28], idx, 2'b00};
  endfunction

  function automatic logic [XLEN-1:0] br_target(input logic [XLEN-1:0] pc,
                                                input logic [15:0] off);
    return pc + 32'd4 + {{14{off[15]}}, off, 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Bundle between the pipeline (decode control, stall, exceptions) and the fetch controller.
// Level signals sampled every cycle; no valid/ready pairing here. stall_f is the only back-pressure.
interface pc_fetch_ctrl_if;
  import pc_fetch_ctrl_pkg::*;

  logic            stall_f;
  logic            flush_exc;
  logic [XLEN-1:0] exc_pc;
  logic            ctrl_d;
  logic            take_d;
  logic            is_j_d;
  logic            jump_to_rs_val_d;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] rs_val_d;
  logic [25:0]     j_index_d;
  logic [15:0]     br_off_d;

  logic            inst_sram_en;
  logic [XLEN-1:0] inst_sram_addr;
  logic [XLEN-1:0] pc_f;
  logic [XLEN-1:0] pc_plus4_f;
  logic            in_ds_f;
  logic            adel_f;
  logic            redirect_pend;

  // Pipeline side: drives the decode-stage info, observes the fetch outputs.
  modport master (
    output stall_f, flush_exc, exc_pc, ctrl_d, take_d, is_j_d, jump_to_rs_val_d,
           pc_d, rs_val_d, j_index_d, br_off_d,
    input  inst_sram_en, inst_sram_addr, pc_f, pc_plus4_f, in_ds_f, adel_f, redirect_pend
  );

  // Fetch controller side.
  modport slave (
    input  stall_f, flush_exc, exc_pc, ctrl_d, take_d, is_j_d, jump_to_rs_val_d,
           pc_d, rs_val_d, j_index_d, br_off_d,
    output inst_sram_en, inst_sram_addr, pc_f, pc_plus4_f, in_ds_f, adel_f, redirect_pend
  );

endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC owner: next-PC selection, stall-time redirect latching and SRAM request.
// Branches resolve in ID, so the IF instruction behind a transfer is its delay slot.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PKG_RESET_PC
) (
  input  logic           clk,
  input  logic           rst,
  pc_fetch_ctrl_if.slave bus
);

  logic [XLEN-1:0] pc_q, pc_d_next;
  logic            pend_v_q;
  logic [XLEN-1:0] pend_tgt_q;
  logic            issue_q;

  logic [XLEN-1:0] tgt;
  logic            taken;

  always_comb begin
    tgt = br_target(bus.pc_d, bus.br_off_d);
    if (bus.jump_to_rs_val_d) begin
      tgt = bus.rs_val_d;
    end else if (bus.is_j_d) begin
      tgt = j_target(bus.pc_d, bus.j_index_d);
    end
  end

  assign taken = bus.ctrl_d & bus.take_d;

  always_comb begin
    pc_d_next = pc_q + 32'd4;
    if (bus.flush_exc) begin
      pc_d_next = bus.exc_pc;
    end else if (pend_v_q) begin
      pc_d_next = pend_tgt_q;
    end else if (taken) begin
      pc_d_next = tgt;
    end
  end

  // Exceptions override stalls; a stalled taken transfer is remembered once,
  // since ID keeps re-presenting the same instruction until the stall lifts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      pend_v_q   <= 1'b0;
      pend_tgt_q <= '0;
      issue_q    <= 1'b0;
    end else begin
      issue_q <= 1'b1;
      if (bus.flush_exc) begin
        pc_q     <= bus.exc_pc;
        pend_v_q <= 1'b0;
      end else if (!bus.stall_f) begin
        pc_q     <= pc_d_next;
        pend_v_q <= 1'b0;
      end else if (taken && !pend_v_q) begin
        pend_v_q   <= 1'b1;
        pend_tgt_q <= tgt;
      end
    end
  end

  assign bus.pc_f           = pc_q;
  assign bus.pc_plus4_f     = pc_q + 32'd4;
  assign bus.adel_f         = (pc_q[1:0] != 2'b00);
  assign bus.inst_sram_en   = issue_q & ~bus.adel_f;
  assign bus.inst_sram_addr = pc_q;
  assign bus.in_ds_f        = bus.ctrl_d & ~pend_v_q;
  assign bus.redirect_pend  = pend_v_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: reset, jumps, branches, stalled redirects,
// exception override, misalignment, PC wrap and asynchronous reset while pending.
module tb_pc_fetch_ctrl;
  import pc_fetch_ctrl_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  pc_fetch_ctrl_if bus();

  pc_fetch_ctrl #(.RESET_PC(32'hBFC0_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.stall_f          = 1'b0;
    bus.flush_exc        = 1'b0;
    bus.exc_pc           = '0;
    bus.ctrl_d           = 1'b0;
    bus.take_d           = 1'b0;
    bus.is_j_d           = 1'b0;
    bus.jump_to_rs_val_d = 1'b0;
    bus.pc_d             = '0;
    bus.rs_val_d         = '0;
    bus.j_index_d        = '0;
    bus.br_off_d         = '0;
  endtask

  task automatic drive_jr(input logic [31:0] rs);
    bus.ctrl_d           = 1'b1;
    bus.take_d           = 1'b1;
    bus.is_j_d           = 1'b0;
    bus.jump_to_rs_val_d = 1'b1;
    bus.rs_val_d         = rs;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    idle_inputs();
    rst = 1'b1;
    step();
    step();

    // Reset state
    chk("rst_pc", bus.pc_f, 32'hBFC0_0000);
    chk("rst_en", {31'd0, bus.inst_sram_en}, 32'd0);
    chk("rst_ds", {31'd0, bus.in_ds_f}, 32'd0);
    chk("rst_pend", {31'd0, bus.redirect_pend}, 32'd0);

    // Reset release: one cycle with no request, then sequential fetch
    rst = 1'b0;
    chk("rel_pc0", bus.pc_f, 32'hBFC0_0000);
    chk("rel_en0", {31'd0, bus.inst_sram_en}, 32'd0);
    step();
    chk("rel_pc1", bus.pc_f, 32'hBFC0_0004);
    chk("rel_en1", {31'd0, bus.inst_sram_en}, 32'd1);
    chk("rel_plus4", bus.pc_plus4_f, 32'hBFC0_0008);
    step();
    chk("rel_pc2", bus.pc_f, 32'hBFC0_0008);
    chk("rel_addr2", bus.inst_sram_addr, 32'hBFC0_0008);

    // jal at BFC00010, index 0x100
    bus.ctrl_d = 1'b1; bus.take_d = 1'b1; bus.is_j_d = 1'b1;
    bus.pc_d = 32'hBFC0_0010; bus.j_index_d = 26'h000_0100;
    #1;
    chk("jal_ds", {31'd0, bus.in_ds_f}, 32'd1);
    step();
    chk("jal_pc", bus.pc_f, 32'hB000_0400);
    idle_inputs();
    #1;
    chk("jal_ds_clr", {31'd0, bus.in_ds_f}, 32'd0);
    step();
    chk("jal_seq", bus.pc_f, 32'hB000_0404);

    // j whose pc_d+4 crosses a 256MB region boundary
    bus.ctrl_d = 1'b1; bus.take_d = 1'b1; bus.is_j_d = 1'b1;
    bus.pc_d = 32'hAFFF_FFFC; bus.j_index_d = 26'h3FF_FFFF;
    step();
    chk("j_region", bus.pc_f, 32'hBFFF_FFFC);
    idle_inputs();

    // beq taken, offset -1
    bus.ctrl_d = 1'b1; bus.take_d = 1'b1; bus.pc_d = 32'h0040_0000; bus.br_off_d = 16'hFFFF;
    step();
    chk("beq_neg", bus.pc_f, 32'h0040_0000);

    // Branch not taken: sequential, nothing pending
    bus.take_d = 1'b0; bus.br_off_d = 16'h0100;
    step();
    chk("bnt_pc", bus.pc_f, 32'h0040_0004);
    chk("bnt_pend", {31'd0, bus.redirect_pend}, 32'd0);

    // Taken branch, positive offset
    bus.take_d = 1'b1; bus.pc_d = 32'h0040_0004; bus.br_off_d = 16'h0010;
    step();
    chk("br_pos", bus.pc_f, 32'h0040_0048);
    idle_inputs();

    // jr with stall for 3 cycles; rs changes mid-stall, first target must win
    drive_jr(32'h8000_0180);
    bus.stall_f = 1'b1;
    step();
    chk("jr_pend1", {31'd0, bus.redirect_pend}, 32'd1);
    chk("jr_hold1", bus.pc_f, 32'h0040_0048);
    chk("jr_ds_pend", {31'd0, bus.in_ds_f}, 32'd0);
    bus.rs_val_d = 32'h1234_5678;
    step();
    step();
    chk("jr_pend3", {31'd0, bus.redirect_pend}, 32'd1);
    chk("jr_hold3", bus.pc_f, 32'h0040_0048);
    idle_inputs();
    step();
    chk("jr_apply", bus.pc_f, 32'h8000_0180);
    chk("jr_pend_clr", {31'd0, bus.redirect_pend}, 32'd0);

    // Exception during stall with a pending jr
    drive_jr(32'h8000_0200);
    bus.stall_f = 1'b1;
    step();
    chk("exc_pend_set", {31'd0, bus.redirect_pend}, 32'd1);
    bus.flush_exc = 1'b1; bus.exc_pc = 32'hBFC0_0380;
    step();
    chk("exc_pc", bus.pc_f, 32'hBFC0_0380);
    chk("exc_pend_clr", {31'd0, bus.redirect_pend}, 32'd0);
    idle_inputs();
    step();
    chk("exc_seq", bus.pc_f, 32'hBFC0_0384);

    // jr to misaligned address
    drive_jr(32'h0040_0002);
    step();
    chk("adel_pc", bus.pc_f, 32'h0040_0002);
    chk("adel_flag", {31'd0, bus.adel_f}, 32'd1);
    chk("adel_en", {31'd0, bus.inst_sram_en}, 32'd0);
    idle_inputs();

    // PC wrap through an exception redirect to the top word
    bus.flush_exc = 1'b1; bus.exc_pc = 32'hFFFF_FFFC;
    step();
    chk("wrap_top", bus.pc_f, 32'hFFFF_FFFC);
    chk("wrap_en", {31'd0, bus.inst_sram_en}, 32'd1);
    idle_inputs();
    step();
    chk("wrap_zero", bus.pc_f, 32'h0000_0000);

    // Asynchronous reset while a redirect is pending
    drive_jr(32'h8000_0300);
    bus.stall_f = 1'b1;
    step();
    chk("arst_pend_pre", {31'd0, bus.redirect_pend}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_pc", bus.pc_f, 32'hBFC0_0000);
    chk("arst_pend", {31'd0, bus.redirect_pend}, 32'd0);
    chk("arst_en", {31'd0, bus.inst_sram_en}, 32'd0);
    idle_inputs();
    step();
    rst = 1'b0;
    step();
    chk("arst_restart", bus.pc_f, 32'hBFC0_0004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
